// File: rtl/pxs_pattern_gen.sv
// pxs_pattern_gen: two-stage test-pattern generator (checker/bars/solid/gradient) with per-frame shadowed settings.
// Define PXS_PATTERN_SCROLL_EN to scroll the checker left by 2 pixels per frame.
module pxs_pattern_gen #(
    parameter int CW         = 1,
    parameter int XGRID_LOG2 = 6,
    parameter int YGRID_LOG2 = 6,
    parameter int BAR_LOG2   = 6,
    parameter int VS_POL     = 0
) (
    input  logic                px_clk,
    input  logic                rst_n,
    input  logic [22:0]         VGA_SCA_Str_i,
    input  logic [1:0]          mode_i,
    input  logic [3*CW-1:0]     fg_i,
    input  logic [3*CW-1:0]     bg_i,
    output logic [23+3*CW-1:0]  VGA_SCA_RGB_Str_o,
    output logic [7:0]          frame_cnt_o
);
    // Sideband layout: {Active, YC[9:0], XC[9:0], VS, HS}
    localparam int VS_B  = 1;
    localparam int XC_L  = 2;
    localparam int YC_L  = 12;
    localparam int ACT_B = 22;
    logic [22:0]        s1_q, s1_d;
    logic [23+3*CW-1:0] out_q, out_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [1:0]         mode_q, mode_d;
    logic [3*CW-1:0]    fg_q, fg_d, bg_q, bg_d, rgb;
    logic [9:0]         xc, yc, xy, xoff, cx, cy, bar;
    logic               fs;
    always_comb begin
        s1_d = VGA_SCA_Str_i;
        xc = s1_q[XC_L +: 10];
        yc = s1_q[YC_L +: 10];
        xy = xc ^ yc;
        // Stage-2 register still holds the previous registered VS
        fs = (s1_q[VS_B] == 1'(VS_POL)) && (out_q[VS_B] != 1'(VS_POL));
        mode_d = fs ? mode_i : mode_q;
        fg_d = fs ? fg_i : fg_q;
        bg_d = fs ? bg_i : bg_q;
        cnt_d = cnt_q + 8'(fs);
`ifdef PXS_PATTERN_SCROLL_EN
        xoff = {1'b0, cnt_q, 1'b0};
`else
        xoff = '0;
`endif
        cx = (xc + xoff) >> XGRID_LOG2;
        cy = yc >> YGRID_LOG2;
        bar = xc >> BAR_LOG2;
        // The _d shadow values are the effective settings, so a frame-start pixel sees the new ones
        rgb = mode_d == 2'd0 ? ((cx[0] ^ cy[0]) ? fg_d : bg_d) :
              mode_d == 2'd1 ? {{CW{bar[2]}}, {CW{bar[1]}}, {CW{bar[0]}}} :
              mode_d == 2'd2 ? fg_d :
                               {xc[9 -: CW], yc[9 -: CW], xy[9 -: CW]};
        out_d = {s1_q[ACT_B] ? rgb : {3*CW{1'b0}}, s1_q};
    end
    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= '0;
            out_q  <= '0;
            cnt_q  <= '0;
            mode_q <= '0;
            fg_q   <= '0;
            bg_q   <= '0;
        end else begin
            s1_q   <= s1_d;
            out_q  <= out_d;
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
            fg_q   <= fg_d;
            bg_q   <= bg_d;
        end
    end
    assign VGA_SCA_RGB_Str_o = out_q;
    assign frame_cnt_o = cnt_q;
endmodule

// File: tb/tb_pxs_pattern_gen.sv
// tb_pxs_pattern_gen: directed checks of pxs_pattern_gen with CW=1, CW=4 and CW=2 instances on a shared timing stream.
module tb_pxs_pattern_gen;
    logic        px_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [22:0] str = '0;
    logic [1:0]  m1 = '0, m4 = '0, m2 = '0;
    logic [2:0]  fg1 = '0, bg1 = '0;
    logic [11:0] fg4 = '0, bg4 = '0;
    logic [5:0]  fg2 = '0, bg2 = '0;
    logic [25:0] o1;
    logic [34:0] o4;
    logic [28:0] o2;
    logic [7:0]  c1, c4, c2;
    int checks = 0;
    int fails = 0;
    int exp_cnt = 0;
    always #5 px_clk = ~px_clk;
    pxs_pattern_gen #(.CW(1)) u1 (.px_clk(px_clk), .rst_n(rst_n), .VGA_SCA_Str_i(str), .mode_i(m1),
        .fg_i(fg1), .bg_i(bg1), .VGA_SCA_RGB_Str_o(o1), .frame_cnt_o(c1));
    pxs_pattern_gen #(.CW(4)) u4 (.px_clk(px_clk), .rst_n(rst_n), .VGA_SCA_Str_i(str), .mode_i(m4),
        .fg_i(fg4), .bg_i(bg4), .VGA_SCA_RGB_Str_o(o4), .frame_cnt_o(c4));
    pxs_pattern_gen #(.CW(2)) u2 (.px_clk(px_clk), .rst_n(rst_n), .VGA_SCA_Str_i(str), .mode_i(m2),
        .fg_i(fg2), .bg_i(bg2), .VGA_SCA_RGB_Str_o(o2), .frame_cnt_o(c2));
    function automatic logic [22:0] pk(input logic hs, input logic vs, input int xc, input int yc, input logic act);
        return {act, 10'(yc), 10'(xc), vs, hs};
    endfunction
    task automatic tick();
        @(posedge px_clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    // VS is active-low: drive it inactive, then active, producing one frame start
    task automatic frame();
        str = pk(1'b1, 1'b1, 0, 0, 1'b0);
        tick();
        tick();
        str = pk(1'b1, 1'b0, 0, 0, 1'b0);
        tick();
        tick();
        exp_cnt = (exp_cnt + 1) % 256;
    endtask
    task automatic pix(input int xc, input int yc, input logic act);
        str = pk(1'b0, 1'b0, xc, yc, act);
        tick();
        tick();
    endtask
    initial begin
        #2;
        chk("reset_out1", 64'(o1), 64'd0);
        chk("reset_out4", 64'(o4), 64'd0);
        chk("reset_cnt", 64'(c1), 64'd0);
        tick();
        rst_n = 1'b1;
        m1 = 2'd0; fg1 = 3'b111; bg1 = 3'b000;
        m4 = 2'd1; fg4 = 12'h123; bg4 = 12'h456;
        m2 = 2'd3;
        frame();
        chk("first_frame_cnt", 64'(c1), 64'(exp_cnt));
        pix(64, 0, 1'b1);
        chk("checker_fg", 64'(o1), 64'({3'b111, str}));
        pix(64, 64, 1'b1);
        chk("checker_bg", 64'(o1), 64'({3'b000, str}));
        pix(320, 0, 1'b1);
        chk("bars_b5", 64'(o4), 64'({12'hF0F, str}));
        pix(320, 0, 1'b0);
        chk("bars_inactive", 64'(o4), 64'({12'h000, str}));
        pix(768, 256, 1'b1);
        chk("gradient", 64'(o2), 64'({6'b11_01_10, str}));
        pix(64, 64, 1'b1);
        m1 = 2'd2;
        pix(64, 64, 1'b1);
        chk("midframe_hold", 64'(o1), 64'({3'b000, str}));
        chk("midframe_cnt", 64'(c1), 64'(exp_cnt));
        frame();
        chk("next_frame_cnt", 64'(c1), 64'(2));
        pix(64, 64, 1'b1);
        chk("solid_after_vs", 64'(o1), 64'({3'b111, str}));
        // Active pixel on the frame-start cycle must already use the new mode
        m1 = 2'd0;
        str = pk(1'b0, 1'b1, 64, 64, 1'b0);
        tick();
        tick();
        str = pk(1'b0, 1'b0, 64, 64, 1'b1);
        tick();
        tick();
        exp_cnt = (exp_cnt + 1) % 256;
        chk("fs_pixel_new_mode", 64'(o1), 64'({3'b000, str}));
        while (exp_cnt != 255) frame();
        chk("cnt_255", 64'(c1), 64'd255);
        frame();
        chk("cnt_wrap", 64'(c1), 64'd0);
        chk("cnt_wrap_u4", 64'(c4), 64'd0);
        for (int i = 0; i < 32; i++) frame();
        chk("cnt_32", 64'(c1), 64'd32);
        pix(0, 0, 1'b1);
`ifdef PXS_PATTERN_SCROLL_EN
        chk("scroll_xoff64", 64'(o1), 64'({3'b111, str}));
`else
        chk("no_scroll", 64'(o1), 64'({3'b000, str}));
`endif
        pix(600, 37, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out1", 64'(o1), 64'd0);
        chk("async_rst_out2", 64'(o2), 64'd0);
        chk("async_rst_cnt", 64'(c1), 64'd0);
        tick();
        rst_n = 1'b1;
        str = pk(1'b1, 1'b1, 100, 5, 1'b0);
        tick();
        chk("post_rst_lat1", 64'(o1), 64'd0);
        tick();
        chk("post_rst_lat2", 64'(o1), 64'({3'b000, str}));
        chk("post_rst_lat2_u4", 64'(o4), 64'({12'h000, str}));
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
